// File: rtl/fb_db_sched_if.sv
// Scheduler <-> draw engine / framebuffer signal bundle for fb_db_sched.
// FB_DB_SCHED_DROP_CNT_EN adds the drop_clr / drop_cnt pair.
interface fb_db_sched_if #(
    parameter int ADDRW = 17,
    parameter int DATAW = 4
);
    logic             frame;
    logic             draw_done;
    logic             draw_we;
    logic [ADDRW-1:0] draw_addr;
    logic [DATAW-1:0] draw_cidx;
    logic             draw_start;
    logic             fb_sel;
    logic             fb0_we;
    logic             fb1_we;
    logic [ADDRW-1:0] fb_addr_write;
    logic [DATAW-1:0] fb_cidx_write;
    logic             busy;
`ifdef FB_DB_SCHED_DROP_CNT_EN
    logic             drop_clr;
    logic [15:0]      drop_cnt;
`endif

    // Scheduler side
    modport slave (
`ifdef FB_DB_SCHED_DROP_CNT_EN
        input  drop_clr,
        output drop_cnt,
`endif
        input  frame, draw_done, draw_we, draw_addr, draw_cidx,
        output draw_start, fb_sel, fb0_we, fb1_we, fb_addr_write, fb_cidx_write, busy
    );

    // Environment side (timing generator, draw engine, framebuffers)
    modport master (
`ifdef FB_DB_SCHED_DROP_CNT_EN
        output drop_clr,
        input  drop_cnt,
`endif
        output frame, draw_done, draw_we, draw_addr, draw_cidx,
        input  draw_start, fb_sel, fb0_we, fb1_we, fb_addr_write, fb_cidx_write, busy
    );
endinterface

// File: rtl/fb_db_sched.sv
// Double-buffered framebuffer scheduler: clear back buffer, start draw, steer writes, swap on frame.
// Optional dropped-frame counter enabled by FB_DB_SCHED_DROP_CNT_EN.
module fb_db_sched #(
    parameter int                PIXELS  = 76800,
    parameter int                ADDRW   = 17,
    parameter int                DATAW   = 4,
    parameter logic [DATAW-1:0]  BG_CIDX = '0
) (
    input  logic           clk,
    input  logic           rst_n,
    fb_db_sched_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_READY,
        ST_CLEAR,
        ST_INIT,
        ST_DRAW
    } state_t;

    localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(PIXELS - 1);

    state_t           r_state;
    logic [ADDRW-1:0] r_cnt;
    logic             r_sel;
    logic             r_start;
    logic             r_we0;
    logic             r_we1;
    logic [ADDRW-1:0] r_addr;
    logic [DATAW-1:0] r_cidx;
    logic             r_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_READY;
            r_cnt   <= '0;
            r_sel   <= 1'b0;
            r_start <= 1'b0;
            r_we0   <= 1'b0;
            r_we1   <= 1'b0;
            r_addr  <= '0;
            r_cidx  <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                ST_READY: begin
                    r_we0 <= 1'b0;
                    r_we1 <= 1'b0;
                    if (bus.frame) begin
                        // Swap now; the first clear write lands in the new back buffer.
                        r_sel   <= ~r_sel;
                        r_state <= ST_CLEAR;
                        r_cnt   <= '0;
                        r_addr  <= '0;
                        r_cidx  <= BG_CIDX;
                        r_we0   <= r_sel;
                        r_we1   <= ~r_sel;
                        r_busy  <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (r_cnt == LAST_ADDR) begin
                        r_we0   <= 1'b0;
                        r_we1   <= 1'b0;
                        r_start <= 1'b1;
                        r_state <= ST_INIT;
                    end else begin
                        r_cnt  <= r_cnt + 1'b1;
                        r_addr <= r_cnt + 1'b1;
                    end
                end
                ST_INIT: begin
                    r_state <= ST_DRAW;
                end
                ST_DRAW: begin
                    // A write coinciding with draw_done is still the engine's last pixel.
                    r_we0  <= bus.draw_we & ~r_sel;
                    r_we1  <= bus.draw_we & r_sel;
                    r_addr <= bus.draw_addr;
                    r_cidx <= bus.draw_cidx;
                    if (bus.draw_done) begin
                        r_state <= ST_READY;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_READY;
                    r_we0   <= 1'b0;
                    r_we1   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.draw_start    = r_start;
    assign bus.fb_sel        = r_sel;
    assign bus.fb0_we        = r_we0;
    assign bus.fb1_we        = r_we1;
    assign bus.fb_addr_write = r_addr;
    assign bus.fb_cidx_write = r_cidx;
    assign bus.busy          = r_busy;

`ifdef FB_DB_SCHED_DROP_CNT_EN
    logic        w_drop;
    logic [15:0] r_drop_cnt;

    assign w_drop = bus.frame && (r_state != ST_READY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else if (bus.drop_clr) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign bus.drop_cnt = r_drop_cnt;
`endif
endmodule

// File: tb/tb_fb_db_sched.sv
// Self-checking bench for fb_db_sched: directed scenarios plus random traffic against a timeline model.
// Build with FB_DB_SCHED_DROP_CNT_EN to also exercise the drop counter.
module tb_fb_db_sched;
    localparam int         PIXELS = 16;
    localparam int         ADDRW  = 5;
    localparam int         DATAW  = 4;
    localparam logic [3:0] BG     = 4'h3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fb_db_sched_if #(.ADDRW(ADDRW), .DATAW(DATAW)) bus();

    fb_db_sched #(
        .PIXELS (PIXELS),
        .ADDRW  (ADDRW),
        .DATAW  (DATAW),
        .BG_CIDX(BG)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: m_k counts cycles since the accepted frame (1..16 clear, 17 init, >=18 draw).
    bit         m_active = 1'b0;
    int         m_k      = 0;
    logic       m_sel    = 1'b0;
    int         m_drops  = 0;
    logic       e_we     = 1'b0;
    logic       e_start  = 1'b0;
    logic       e_busy   = 1'b0;
    logic [4:0] e_addr   = '0;
    logic [3:0] e_cidx   = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic f, input logic d, input logic we,
                              input logic [4:0] a, input logic [3:0] c, input logic clr);
        bit drop;
        drop    = f && m_active;
        e_we    = 1'b0;
        e_start = 1'b0;
        if (!m_active) begin
            if (f) begin
                m_active = 1'b1;
                m_k      = 1;
                m_sel    = ~m_sel;
                e_we     = 1'b1;
                e_addr   = '0;
                e_cidx   = BG;
                $display("frame accepted: drawing into fb%0d at %0t", m_sel, $time);
            end
        end else if (m_k <= PIXELS - 1) begin
            e_we   = 1'b1;
            e_addr = 5'(m_k);
            e_cidx = BG;
            m_k++;
        end else if (m_k == PIXELS) begin
            e_start = 1'b1;
            m_k++;
        end else if (m_k == PIXELS + 1) begin
            m_k++;
        end else begin
            e_we   = we;
            e_addr = a;
            e_cidx = c;
            if (d) m_active = 1'b0;
        end
        e_busy = m_active;
        if (clr)                          m_drops = 0;
        else if (drop && m_drops < 65535) m_drops++;
    endtask

    task automatic check_outputs();
        chk("fb_sel", 32'(bus.fb_sel), 32'(m_sel));
        chk("fb0_we", 32'(bus.fb0_we), 32'(e_we && !m_sel));
        chk("fb1_we", 32'(bus.fb1_we), 32'(e_we && m_sel));
        chk("draw_start", 32'(bus.draw_start), 32'(e_start));
        chk("busy", 32'(bus.busy), 32'(e_busy));
        if (e_we) begin
            chk("fb_addr_write", 32'(bus.fb_addr_write), 32'(e_addr));
            chk("fb_cidx_write", 32'(bus.fb_cidx_write), 32'(e_cidx));
        end
`ifdef FB_DB_SCHED_DROP_CNT_EN
        chk("drop_cnt", 32'(bus.drop_cnt), 32'(m_drops));
`endif
    endtask

    task automatic cycle(input logic f, input logic d, input logic we,
                         input logic [4:0] a, input logic [3:0] c, input logic clr);
        bus.frame     = f;
        bus.draw_done = d;
        bus.draw_we   = we;
        bus.draw_addr = a;
        bus.draw_cidx = c;
`ifdef FB_DB_SCHED_DROP_CNT_EN
        bus.drop_clr  = clr;
`endif
        @(posedge clk);
        model_edge(f, d, we, a, c, clr);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 1'b0, 1'b0, 5'd0, 4'd0, 1'b0);
    endtask

    // Start a frame if idle, then advance until the model is in the draw phase.
    task automatic run_to_draw();
        if (!m_active) cycle(1'b1, 1'b0, 1'b0, 5'd0, 4'd0, 1'b0);
        for (int i = 0; i < 40 && m_k < PIXELS + 2; i++) idle(1);
        chk("reached_draw", 32'(m_k >= PIXELS + 2), 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_fb_sel"}, 32'(bus.fb_sel), 32'd0);
        chk({tag, "_fb0_we"}, 32'(bus.fb0_we), 32'd0);
        chk({tag, "_fb1_we"}, 32'(bus.fb1_we), 32'd0);
        chk({tag, "_draw_start"}, 32'(bus.draw_start), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_addr"}, 32'(bus.fb_addr_write), 32'd0);
        chk({tag, "_cidx"}, 32'(bus.fb_cidx_write), 32'd0);
`ifdef FB_DB_SCHED_DROP_CNT_EN
        chk({tag, "_drop_cnt"}, 32'(bus.drop_cnt), 32'd0);
`endif
    endtask

    initial begin
        logic       f, d, we, clr;
        logic [4:0] a;
        logic [3:0] c;

        bus.frame     = 1'b0;
        bus.draw_done = 1'b0;
        bus.draw_we   = 1'b0;
        bus.draw_addr = '0;
        bus.draw_cidx = '0;
`ifdef FB_DB_SCHED_DROP_CNT_EN
        bus.drop_clr  = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk) rst_n = 1'b1;
        idle(2);

        // First frame: clear fb1 while the draw engine pokes at the bus (must be ignored).
        cycle(1'b1, 1'b0, 1'b0, 5'd0, 4'd0, 1'b0);
        chk("first_swap_sel", 32'(bus.fb_sel), 32'd1);
        for (int i = 0; i < PIXELS; i++) cycle(1'b0, 1'b0, i[0], 5'd7, 4'hB, 1'b0);
        idle(1);
        cycle(1'b0, 1'b0, 1'b1, 5'd7, 4'hB, 1'b0);
        chk("draw_fb1_we", 32'(bus.fb1_we), 32'd1);
        chk("draw_fb0_we", 32'(bus.fb0_we), 32'd0);
        chk("draw_addr7", 32'(bus.fb_addr_write), 32'd7);
        chk("draw_cidxB", 32'(bus.fb_cidx_write), 32'hB);
        cycle(1'b0, 1'b1, 1'b1, 5'd20, 4'h9, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, i[0], 1'b1, 5'd3, 4'hE, 1'b0);

        // Second frame clears fb0; a frame mid-draw is dropped.
        run_to_draw();
        chk("second_swap_sel", 32'(bus.fb_sel), 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 5'd0, 4'd0, 1'b0);
        idle(4);
        cycle(1'b0, 1'b1, 1'b0, 5'd0, 4'd0, 1'b0);
        chk("after_drop_busy", 32'(bus.busy), 32'd0);
        chk("after_drop_sel", 32'(bus.fb_sel), 32'd0);
        idle(2);

        // Next frame swaps; then draw_done together with frame is a drop without swap.
        run_to_draw();
        chk("third_swap_sel", 32'(bus.fb_sel), 32'd1);
        cycle(1'b1, 1'b1, 1'b0, 5'd0, 4'd0, 1'b0);
        chk("done_frame_sel", 32'(bus.fb_sel), 32'd1);
        idle(2);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            f   = m_active ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 3) == 0);
            d   = (m_active && m_k >= PIXELS + 2) ? ($urandom_range(0, 7) == 0)
                                                  : ($urandom_range(0, 9) == 0);
            we  = $urandom_range(0, 1) == 1;
            a   = 5'($urandom);
            c   = 4'($urandom);
            clr = $urandom_range(0, 19) == 0;
            cycle(f, d, we, a, c, clr);
        end

`ifdef FB_DB_SCHED_DROP_CNT_EN
        // Saturate the drop counter, then clear it on a cycle that is also a drop.
        run_to_draw();
        cycle(1'b0, 1'b0, 1'b0, 5'd0, 4'd0, 1'b1);
        for (int i = 0; i < 65537; i++) cycle(1'b1, 1'b0, 1'b0, 5'd0, 4'd0, 1'b0);
        chk("drop_saturated", 32'(bus.drop_cnt), 32'hFFFF);
        cycle(1'b1, 1'b0, 1'b0, 5'd0, 4'd0, 1'b1);
        chk("drop_clr_wins", 32'(bus.drop_cnt), 32'd0);
        cycle(1'b0, 1'b1, 1'b0, 5'd0, 4'd0, 1'b0);
        idle(2);
`endif

        // Asynchronous reset in the middle of a clear.
        if (m_active) begin
            run_to_draw();
            cycle(1'b0, 1'b1, 1'b0, 5'd0, 4'd0, 1'b0);
        end
        cycle(1'b1, 1'b0, 1'b0, 5'd0, 4'd0, 1'b0);
        for (int i = 0; i < 20 && m_k < 10; i++) idle(1);
        chk("mid_clear_addr9", 32'(bus.fb_addr_write), 32'd9);
        #2 rst_n = 1'b0;
        #1;
        m_active = 1'b0;
        m_k      = 0;
        m_sel    = 1'b0;
        m_drops  = 0;
        e_we     = 1'b0;
        e_start  = 1'b0;
        e_busy   = 1'b0;
        check_reset_values("async_reset");
        @(posedge clk);
        #1;
        check_reset_values("held_reset");
        @(negedge clk) rst_n = 1'b1;
        idle(2);
        run_to_draw();
        chk("restart_sel", 32'(bus.fb_sel), 32'd1);
        cycle(1'b0, 1'b1, 1'b0, 5'd0, 4'd0, 1'b0);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fb_db_sched.md
Name: fb_db_sched

Overview:
- Frame scheduler for a double-buffered framebuffer pair.
- Each frame it selects the back buffer, clears it to a background colour, starts the external shape-drawing engine, and steers that engine's writes into the back buffer.
- It swaps the front and back buffers only at a frame boundary after drawing has finished, so the display never shows a partly drawn frame.
- Sits between the draw engine / pixel-address stage and the two simple-dual-port framebuffer BRAMs.

Parameters:
- PIXELS, 76800, pixels per buffer; clear covers addresses 0..PIXELS-1.
- ADDRW, 17, write-address width; must satisfy 2^ADDRW >= PIXELS.
- DATAW, 4, colour-index width.
- BG_CIDX, 0, colour index written during clear.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- frame  in  1  one-cycle pulse at start of vertical blanking.
- draw_done  in  1  one-cycle pulse from draw engine when its job is complete.
- draw_we  in  1  draw-engine write strobe.
- draw_addr  in  ADDRW  draw-engine write address.
- draw_cidx  in  DATAW  draw-engine colour index.
- draw_start  out  1  one-cycle pulse starting the draw engine.
- fb_sel  out  1  buffer being drawn (0 = fb0, 1 = fb1); display reads the other.
- fb0_we  out  1  write enable, buffer 0.
- fb1_we  out  1  write enable, buffer 1.
- fb_addr_write  out  ADDRW  shared write address.
- fb_cidx_write  out  DATAW  shared write data.
- busy  out  1  high in CLEAR, INIT, DRAW.

Behaviour:
- Reset state: READY. fb_sel=0; draw_start=0; fb0_we=0; fb1_we=0; fb_addr_write=0; fb_cidx_write=0; busy=0. Clear counter = 0.
- All outputs are registered.
- States and transitions:
  - READY: frame=1 -> toggle fb_sel, enter CLEAR, clear counter <= 0.
  - CLEAR: one write per cycle. Address = counter, data = BG_CIDX. When counter == PIXELS-1 -> INIT.
  - INIT: exactly one cycle. draw_start=1, no write.
  - DRAW: draw_done=1 -> READY.
- Clear timing: frame sampled in READY at cycle F gives:
  - F+1: fb_sel toggled; first clear write at address 0.
  - F+PIXELS: last clear write at address PIXELS-1.
  - F+PIXELS+1: INIT, draw_start=1.
  - F+PIXELS+2: DRAW.
- Write steering: the write enable goes only to the buffer selected by fb_sel; the other buffer's we is 0.
- Draw path in DRAW: draw_we/draw_addr/draw_cidx sampled at cycle t appear on the selected fbN_we/fb_addr_write/fb_cidx_write at t+1.
- In READY, CLEAR and INIT, draw_* inputs are ignored and no draw write is emitted. A draw_we arriving in the same cycle as the draw_done that ends DRAW is still passed through.
- Frame overrun: frame in CLEAR, INIT or DRAW is a dropped frame.
  - No swap occurs; current work continues.
  - The block then waits in READY for the next frame.
- Simultaneous draw_done and frame in DRAW: enter READY with no swap; counts as a drop.
- frame in READY with draw_done also high: draw_done is ignored.
- Clear counter is ADDRW bits and resets to 0 on each CLEAR entry; it never wraps past PIXELS-1.
- rst_n low at any time, including mid-clear or mid-draw, forces reset values immediately, asynchronously. Operation restarts in READY with fb_sel=0.

Optional Feature:
- Macro: FB_DB_SCHED_DROP_CNT_EN.
- When defined:
  - Adds output drop_cnt (16 bits), reset to 0.
  - Increments by 1 on each dropped frame; saturates at 16'hFFFF.
  - Adds input drop_clr (1 bit), which synchronously zeroes drop_cnt. drop_clr has priority over a simultaneous increment.
- When undefined: neither port exists, and dropped-frame behaviour is otherwise identical.

Test Plan (PIXELS=16, ADDRW=5, BG_CIDX=4'h3):
- Reset release, frame at cycle F -> fb_sel=1 at F+1; fb1_we=1 with addresses 0..15 and data 3 on F+1..F+16; fb0_we=0 throughout; draw_start=1 at F+17 only.
- In DRAW with fb_sel=1, draw_we=1, addr=7, cidx=4'hB at cycle t -> at t+1: fb1_we=1, addr 7, data B, fb0_we=0. draw_done -> READY; next frame -> fb_sel=0 and clear targets fb0.
- draw_we pulses during CLEAR and READY -> no write with draw address or data; only the clear sequence appears.
- frame during DRAW, draw_done 5 cycles later -> fb_sel unchanged, state READY, drop_cnt=1 (macro on). Following frame swaps.
- draw_done and frame in the same cycle -> no swap, READY, drop_cnt increments. rst_n low mid-CLEAR at address 9 -> all outputs at reset values immediately, fb_sel=0.
- Macro on: drop_cnt preloaded to 16'hFFFF plus one drop -> stays FFFF. drop_clr together with a drop -> drop_cnt=0.
